// File: rtl/accel_perf_monitor.sv
// Run monitor for the accelerator: per-run cycle/transfer/stall/output counters,
// sticky protocol and health error flags, and a registered counter read port.
module accel_perf_monitor #(
  parameter int unsigned NB_STREAMS         = 2,
  parameter int unsigned CNT_WIDTH          = 32,
  parameter int unsigned FEATURE_MAP_WIDTH  = 64,
  parameter int unsigned FEATURE_MAP_HEIGHT = 64,
  parameter int unsigned OUTPUT_NB_CHANNELS = 32,
  parameter int unsigned COORD_WIDTH        = 32,
  parameter int unsigned TIMEOUT_CYCLES     = 1024,
  parameter int unsigned SEL_WIDTH          = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   running,
  input  logic [NB_STREAMS-1:0]  s_valid,
  input  logic [NB_STREAMS-1:0]  s_ready,
  input  logic                   output_valid,
  input  logic [COORD_WIDTH-1:0] output_x,
  input  logic [COORD_WIDTH-1:0] output_y,
  input  logic [COORD_WIDTH-1:0] output_ch,
  input  logic [SEL_WIDTH-1:0]   stat_sel,
  output logic [CNT_WIDTH-1:0]   stat_data,
  output logic                   done,
  output logic [4:0]             err
);

  localparam int unsigned WD_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WD_WIDTH-1:0]  WD_MAX  = WD_WIDTH'(TIMEOUT_CYCLES);
  localparam longint unsigned EXP_OUTPUTS =
    64'(FEATURE_MAP_WIDTH) * 64'(FEATURE_MAP_HEIGHT) * 64'(OUTPUT_NB_CHANNELS);

  typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [CNT_WIDTH-1:0] out_cnt_q, out_cnt_d;
  logic [CNT_WIDTH-1:0] xfer_cnt_q  [NB_STREAMS];
  logic [CNT_WIDTH-1:0] xfer_cnt_d  [NB_STREAMS];
  logic [CNT_WIDTH-1:0] stall_cnt_q [NB_STREAMS];
  logic [CNT_WIDTH-1:0] stall_cnt_d [NB_STREAMS];
  logic [WD_WIDTH-1:0]  wd_q, wd_d;
  logic [4:0]           err_q, err_d;
  logic [CNT_WIDTH-1:0] stat_q, stat_d;
  logic                 done_q;

  logic active, counting, idle_or_done, any_hs, out_of_range, sat_hit;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_WIDTH'(1);
  endfunction

  // True when this increment lands on (or stays at) the saturation value.
  function automatic logic near_max(input logic [CNT_WIDTH-1:0] v);
    return v >= (CNT_MAX - CNT_WIDTH'(1));
  endfunction

  assign active       = (state_q == ARMED) || (state_q == RUN);
  assign counting     = active && running;
  assign idle_or_done = (state_q == IDLE) || (state_q == DONE);
  assign any_hs       = |(s_valid & s_ready);
  assign out_of_range = (64'(output_x)  >= 64'(FEATURE_MAP_WIDTH))  ||
                        (64'(output_y)  >= 64'(FEATURE_MAP_HEIGHT)) ||
                        (64'(output_ch) >= 64'(OUTPUT_NB_CHANNELS));

  // Next-state, counter, watchdog, error and read-mux logic.
  always_comb begin
    state_d     = state_q;
    cyc_cnt_d   = cyc_cnt_q;
    out_cnt_d   = out_cnt_q;
    xfer_cnt_d  = xfer_cnt_q;
    stall_cnt_d = stall_cnt_q;
    wd_d        = wd_q;
    err_d       = err_q;
    stat_d      = '0;
    sat_hit     = 1'b0;

    case (state_q)
      IDLE, DONE: if (start)    state_d = ARMED;
      ARMED:      if (running)  state_d = RUN;
      RUN:        if (!running) state_d = DONE;
      default:                  state_d = IDLE;
    endcase

    if (counting) begin
      cyc_cnt_d = sat_inc(cyc_cnt_q);
      sat_hit   = sat_hit | near_max(cyc_cnt_q);
      for (int unsigned i = 0; i < NB_STREAMS; i++) begin
        if (s_valid[i] && s_ready[i]) begin
          xfer_cnt_d[i] = sat_inc(xfer_cnt_q[i]);
          sat_hit       = sat_hit | near_max(xfer_cnt_q[i]);
        end else if (s_valid[i]) begin
          stall_cnt_d[i] = sat_inc(stall_cnt_q[i]);
          sat_hit        = sat_hit | near_max(stall_cnt_q[i]);
        end
      end
    end

    // Beats are counted in ARMED/RUN even with running low to catch trailing outputs.
    if (active && output_valid) begin
      out_cnt_d = sat_inc(out_cnt_q);
      sat_hit   = sat_hit | near_max(out_cnt_q);
    end

    if (output_valid && out_of_range) err_d[0] = 1'b1;
    if (output_valid && idle_or_done) err_d[3] = 1'b1;
    if (sat_hit)                      err_d[4] = 1'b1;

    if (state_q == RUN) begin
      if (any_hs || output_valid) begin
        wd_d = '0;
      end else begin
        if (wd_q != WD_MAX) wd_d = wd_q + WD_WIDTH'(1);
        if (wd_q >= WD_MAX - WD_WIDTH'(1)) err_d[2] = 1'b1;
      end
    end

    if ((state_q == RUN) && !running && (64'(out_cnt_d) != EXP_OUTPUTS)) err_d[1] = 1'b1;

    if (idle_or_done && start) begin
      cyc_cnt_d = '0;
      out_cnt_d = '0;
      for (int unsigned i = 0; i < NB_STREAMS; i++) begin
        xfer_cnt_d[i]  = '0;
        stall_cnt_d[i] = '0;
      end
      wd_d  = '0;
      err_d = '0;
    end

    if (32'(stat_sel) == 32'd0) stat_d = cyc_cnt_q;
    if (32'(stat_sel) == 32'd1) stat_d = out_cnt_q;
    for (int unsigned i = 0; i < NB_STREAMS; i++) begin
      if (32'(stat_sel) == 32'(2 + 2 * i)) stat_d = xfer_cnt_q[i];
      if (32'(stat_sel) == 32'(3 + 2 * i)) stat_d = stall_cnt_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cyc_cnt_q <= '0;
      out_cnt_q <= '0;
      for (int unsigned i = 0; i < NB_STREAMS; i++) begin
        xfer_cnt_q[i]  <= '0;
        stall_cnt_q[i] <= '0;
      end
      wd_q   <= '0;
      err_q  <= '0;
      stat_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_cnt_q <= cyc_cnt_d;
      out_cnt_q <= out_cnt_d;
      for (int unsigned i = 0; i < NB_STREAMS; i++) begin
        xfer_cnt_q[i]  <= xfer_cnt_d[i];
        stall_cnt_q[i] <= stall_cnt_d[i];
      end
      wd_q   <= wd_d;
      err_q  <= err_d;
      stat_q <= stat_d;
      done_q <= (state_d == DONE);
    end
  end

  assign stat_data = stat_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_accel_perf_monitor.sv
// Bench for accel_perf_monitor: two instances (32-bit and 4-bit counters) share
// one directed stimulus and are compared every cycle against an unbounded-count model.
module tb_accel_perf_monitor;

  localparam int unsigned NS = 2;
  localparam int unsigned FW = 4;
  localparam int unsigned FH = 4;
  localparam int unsigned FC = 2;
  localparam int unsigned TO = 8;
  localparam int S_IDLE = 0, S_ARMED = 1, S_RUN = 2, S_DONE = 3;

  logic        clk = 1'b0;
  logic        rst, start, running, output_valid;
  logic [1:0]  s_valid, s_ready;
  logic [31:0] ox, oy, och;
  logic [3:0]  stat_sel;
  logic [31:0] stat_a;
  logic [3:0]  stat_b;
  logic        done_a, done_b;
  logic [4:0]  err_a, err_b;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  accel_perf_monitor #(
    .NB_STREAMS(NS), .CNT_WIDTH(32), .FEATURE_MAP_WIDTH(FW), .FEATURE_MAP_HEIGHT(FH),
    .OUTPUT_NB_CHANNELS(FC), .COORD_WIDTH(32), .TIMEOUT_CYCLES(TO), .SEL_WIDTH(4)
  ) dut_a (
    .clk(clk), .rst(rst), .start(start), .running(running),
    .s_valid(s_valid), .s_ready(s_ready), .output_valid(output_valid),
    .output_x(ox), .output_y(oy), .output_ch(och), .stat_sel(stat_sel),
    .stat_data(stat_a), .done(done_a), .err(err_a)
  );

  accel_perf_monitor #(
    .NB_STREAMS(NS), .CNT_WIDTH(4), .FEATURE_MAP_WIDTH(FW), .FEATURE_MAP_HEIGHT(FH),
    .OUTPUT_NB_CHANNELS(FC), .COORD_WIDTH(32), .TIMEOUT_CYCLES(TO), .SEL_WIDTH(4)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start), .running(running),
    .s_valid(s_valid), .s_ready(s_ready), .output_valid(output_valid),
    .output_x(ox), .output_y(oy), .output_ch(och), .stat_sel(stat_sel),
    .stat_data(stat_b), .done(done_b), .err(err_b)
  );

  // Model: raw event counts are unbounded; saturation is applied only when observed.
  int         m_state [2];
  longint     m_cyc [2], m_out [2], m_wd [2], m_stat [2];
  longint     m_xfer [2][NS];
  longint     m_stall [2][NS];
  logic [4:0] m_err [2];
  logic       m_done [2];

  function automatic longint cmax(int k);
    return (k == 0) ? ((64'd1 << 32) - 1) : 64'd15;
  endfunction

  function automatic longint sat(int k, longint v);
    return (v > cmax(k)) ? cmax(k) : v;
  endfunction

  function automatic longint sel_val(int k, int s);
    if (s == 0) return sat(k, m_cyc[k]);
    if (s == 1) return sat(k, m_out[k]);
    if (s >= 2 && s < 2 + 2 * NS) begin
      if (s % 2 == 0) return sat(k, m_xfer[k][(s - 2) / 2]);
      return sat(k, m_stall[k][(s - 2) / 2]);
    end
    return 0;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_state[k] = S_IDLE; m_cyc[k] = 0; m_out[k] = 0; m_wd[k] = 0;
        m_err[k] = '0; m_stat[k] = 0;
        for (int i = 0; i < NS; i++) begin m_xfer[k][i] = 0; m_stall[k][i] = 0; end
      end else begin
        m_stat[k] = sel_val(k, int'(stat_sel));
        if ((m_state[k] == S_IDLE || m_state[k] == S_DONE) && start) begin
          m_state[k] = S_ARMED; m_cyc[k] = 0; m_out[k] = 0; m_wd[k] = 0; m_err[k] = '0;
          for (int i = 0; i < NS; i++) begin m_xfer[k][i] = 0; m_stall[k][i] = 0; end
        end else begin
          bit act, hs, big;
          act = (m_state[k] == S_ARMED || m_state[k] == S_RUN);
          hs  = 1'b0;
          for (int i = 0; i < NS; i++) if (s_valid[i] && s_ready[i]) hs = 1'b1;
          if (act && running) begin
            m_cyc[k]++;
            for (int i = 0; i < NS; i++) begin
              if (s_valid[i] && s_ready[i]) m_xfer[k][i]++;
              if (s_valid[i] && !s_ready[i]) m_stall[k][i]++;
            end
          end
          if (act && output_valid) m_out[k]++;
          if (output_valid && (ox >= FW || oy >= FH || och >= FC)) m_err[k][0] = 1'b1;
          if (output_valid && !act) m_err[k][3] = 1'b1;
          if (m_state[k] == S_RUN) begin
            if (hs || output_valid) m_wd[k] = 0;
            else m_wd[k]++;
            if (m_wd[k] >= TO) m_err[k][2] = 1'b1;
          end
          big = (m_cyc[k] >= cmax(k)) || (m_out[k] >= cmax(k));
          for (int i = 0; i < NS; i++)
            if (m_xfer[k][i] >= cmax(k) || m_stall[k][i] >= cmax(k)) big = 1'b1;
          if (big) m_err[k][4] = 1'b1;
          if (m_state[k] == S_ARMED && running) m_state[k] = S_RUN;
          else if (m_state[k] == S_RUN && !running) begin
            m_state[k] = S_DONE;
            if (sat(k, m_out[k]) != FW * FH * FC) m_err[k][1] = 1'b1;
          end
        end
      end
      m_done[k] = (m_state[k] == S_DONE);
    end
  end

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("a_done", 64'(done_a), 64'(m_done[0]));
      check("a_err",  64'(err_a),  64'(m_err[0]));
      check("a_stat", 64'(stat_a), 64'(m_stat[0]));
      check("b_done", 64'(done_b), 64'(m_done[1]));
      check("b_err",  64'(err_b),  64'(m_err[1]));
      check("b_stat", 64'(stat_b), 64'(m_stat[1]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    start = 0; running = 0; s_valid = 0; s_ready = 0; output_valid = 0;
    ox = 0; oy = 0; och = 0;
  endtask

  task automatic read_a(int sel, longint exp, string name);
    stat_sel = 4'(sel);
    tick();
    check(name, 64'(stat_a), 64'(exp));
  endtask

  initial begin
    longint t1_exp [7];
    t1_exp = '{40, 32, 40, 0, 40, 0, 0};
    quiet(); stat_sel = 0; rst = 1;
    tick(); chk_en = 1'b1; tick();
    check("rst_done", 64'(done_a), 64'd0);
    check("rst_err",  64'(err_a),  64'd0);
    check("rst_stat", 64'(stat_a), 64'd0);
    rst = 0;

    // Nominal run: 40 counting cycles, 32 in-range beats, both streams transferring.
    start = 1; tick(); start = 0;
    for (int i = 0; i < 40; i++) begin
      running = 1; s_valid = 2'b11; s_ready = 2'b11;
      output_valid = (i < 32);
      ox = 32'(i % 4); oy = 32'((i / 4) % 4); och = 32'(i / 16);
      tick();
    end
    quiet(); tick();
    check("t1_done",  64'(done_a), 64'd1);
    check("t1_err",   64'(err_a),  64'd0);
    check("t1_errb",  64'(err_b),  64'b10010);
    for (int s = 0; s < 7; s++) read_a(s, t1_exp[s], $sformatf("t1_sel%0d", s));

    // Stream 1 stalls for 10 cycles; one beat with channel out of range.
    start = 1; tick(); start = 0;
    for (int i = 0; i < 10; i++) begin
      running = 1; s_valid = 2'b11; s_ready = 2'b01;
      output_valid = (i == 3); och = (i == 3) ? 32'd2 : 32'd0;
      tick();
    end
    quiet(); tick();
    check("t2_err", 64'(err_a), 64'b00011);
    read_a(5, 10, "t2_stall1");
    read_a(4, 0,  "t2_xfer1");
    read_a(2, 10, "t2_xfer0");

    // Short run of 31 beats.
    start = 1; tick(); start = 0;
    for (int i = 0; i < 31; i++) begin
      running = 1; output_valid = 1;
      ox = 32'(i % 4); oy = 32'((i / 4) % 4); och = 32'(i / 16);
      tick();
    end
    quiet(); tick();
    check("t3_err", 64'(err_a), 64'b00010);
    read_a(1, 31, "t3_out");

    // Watchdog: ARMED->RUN, then 8 idle RUN cycles.
    start = 1; tick(); start = 0;
    running = 1; tick();
    for (int i = 0; i < 7; i++) tick();
    check("t4_wd7", 64'(err_a[2]), 64'd0);
    tick();
    check("t4_wd8", 64'(err_a[2]), 64'd1);
    output_valid = 1; tick(); output_valid = 0;
    check("t4_sticky", 64'(err_a[2]), 64'd1);
    running = 0; tick();

    // Spurious beat in DONE, then start clears flags and counters.
    output_valid = 1; tick(); output_valid = 0;
    check("t5_spur_done", 64'(err_a), 64'b01110);
    stat_sel = 0; start = 1; tick(); start = 0;
    check("t5_clr_err", 64'(err_a), 64'd0);
    tick();
    check("t5_clr_cyc", 64'(stat_a), 64'd0);
    rst = 1; tick(); rst = 0;
    output_valid = 1; tick(); output_valid = 0;
    check("t5_spur_idle", 64'(err_a), 64'b01000);

    // Saturation on the 4-bit instance, then reset mid-run.
    start = 1; tick(); start = 0;
    stat_sel = 0;
    for (int i = 0; i < 20; i++) begin
      running = 1; s_valid = 2'b11; s_ready = 2'b11; tick();
    end
    check("t6_sat_err", 64'(err_b[4]), 64'd1);
    tick();
    check("t6_cyc_b", 64'(stat_b), 64'd15);
    check("t6_cyc_a", 64'(stat_a), 64'd20);
    rst = 1; tick(); rst = 0;
    check("t6_rst_done", 64'(done_a), 64'd0);
    check("t6_rst_stat", 64'(stat_a), 64'd0);
    check("t6_rst_err",  64'(err_b),  64'd0);
    tick(); tick();
    check("t6_idle_nocount", 64'(stat_a), 64'd0);

    quiet(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
